// File: rtl/move_check_sequencer_pkg.sv
// Shared chess types and helpers for the move-check sequencer and its checkers.
// Contents: piece codes, result codes, one-hot checker bit indices,
//           and small piece-classification functions.
package chess_pkg;

  typedef enum logic [3:0] {
    W_KING   = 4'd0,
    W_QUEEN  = 4'd1,
    W_ROOK   = 4'd2,
    W_BISHOP = 4'd3,
    W_KNIGHT = 4'd4,
    W_PAWN   = 4'd5,
    B_KING   = 4'd6,
    B_QUEEN  = 4'd7,
    B_ROOK   = 4'd8,
    B_BISHOP = 4'd9,
    B_KNIGHT = 4'd10,
    B_PAWN   = 4'd11,
    EMPTY    = 4'd15
  } piece_t;

  typedef enum logic [2:0] {
    RC_OK          = 3'd0,
    RC_EMPTY_SRC   = 3'd1,
    RC_WRONG_TURN  = 3'd2,
    RC_OWN_CAPTURE = 3'd3,
    RC_NULL_MOVE   = 3'd4,
    RC_RULE_FAIL   = 3'd5,
    RC_TIMEOUT     = 3'd6
  } result_code_t;

  localparam int NUM_CHK    = 6;
  localparam int CHK_KING   = 0;
  localparam int CHK_QUEEN  = 1;
  localparam int CHK_ROOK   = 2;
  localparam int CHK_BISHOP = 3;
  localparam int CHK_KNIGHT = 4;
  localparam int CHK_PAWN   = 5;

  // Codes 12..14 are not real pieces and behave exactly like an empty square.
  function automatic logic is_empty(input logic [3:0] p);
    return (p == 4'(EMPTY)) || (p > 4'(B_PAWN));
  endfunction

  function automatic logic is_white(input logic [3:0] p);
    return p <= 4'(W_PAWN);
  endfunction

  // Piece kind independent of colour (code mod 6); only valid for codes 0..11.
  function automatic logic [2:0] piece_kind(input logic [3:0] p);
    logic [3:0] k;
    k = (p >= 4'(B_KING)) ? (p - 4'(B_KING)) : p;
    return k[2:0];
  endfunction

endpackage

// File: rtl/move_check_sequencer_if.sv
// Bus between the game-play FSM / per-piece checkers and the move-check sequencer.
// master: request side plus checker responses; slave: the sequencer itself.
// board_in is indexed [y][x], 4-bit piece code per square.
interface move_check_sequencer_if;
  logic                        start;
  logic [2:0]                  old_x, old_y, new_x, new_y;
  logic                        white_turn;
  logic [7:0][7:0][3:0]        board_in;
  logic                        busy;
  logic [5:0]                  chk_en;
  logic [2:0]                  chk_old_x, chk_old_y, chk_new_x, chk_new_y;
  logic [2:0]                  chk_h_delta, chk_v_delta;
  logic [3:0]                  chk_piece_type;
  logic [5:0]                  chk_done;
  logic [5:0]                  chk_valid;
  logic                        result_valid;
  logic                        result_move;
  logic [2:0]                  result_code;

  modport master (
    output start, old_x, old_y, new_x, new_y, white_turn, board_in,
    output chk_done, chk_valid,
    input  busy, chk_en, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
    input  chk_h_delta, chk_v_delta, chk_piece_type,
    input  result_valid, result_move, result_code
  );

  modport slave (
    input  start, old_x, old_y, new_x, new_y, white_turn, board_in,
    input  chk_done, chk_valid,
    output busy, chk_en, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
    output chk_h_delta, chk_v_delta, chk_piece_type,
    output result_valid, result_move, result_code
  );
endinterface

// File: rtl/move_check_sequencer_abs_delta3.sv
// Unsigned 3-bit absolute difference |a - b|, no wrap-around.
// Ports: a, b (3-bit operands), d (3-bit result). Purely combinational.
module abs_delta3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] d
);
  assign d = (a >= b) ? (a - b) : (b - a);
endmodule

// File: rtl/move_check_sequencer.sv
// Sequences one move-legality check per request: latch squares, fetch pieces,
// run generic rule checks, then hand off to exactly one per-piece checker.
// Ports: clk, reset (sync, active-high), bus (move_check_sequencer_if.slave).
module move_check_sequencer
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  move_check_sequencer_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_PRECHECK = 3'd2,
    S_WAIT     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   old_x_q, old_x_d, old_y_q, old_y_d;
  logic [2:0]   new_x_q, new_x_d, new_y_q, new_y_d;
  logic         wt_q, wt_d;
  logic [3:0]   src_q, src_d, dst_q, dst_d;
  logic [2:0]   h_delta_q, h_delta_d, v_delta_q, v_delta_d;
  logic [5:0]   chk_en_q, chk_en_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         result_valid_q, result_valid_d;
  logic         result_move_q, result_move_d;
  logic [2:0]   result_code_q, result_code_d;

  logic [2:0]   h_delta, v_delta;
  logic         sel_done, sel_valid;

  abs_delta3 u_h_delta (.a(old_x_q), .b(new_x_q), .d(h_delta));
  abs_delta3 u_v_delta (.a(old_y_q), .b(new_y_q), .d(v_delta));

  // Non-selected checkers may raise done at any time; mask them out.
  assign sel_done  = |(bus.chk_done  & chk_en_q);
  assign sel_valid = |(bus.chk_valid & chk_en_q);

  always_comb begin
    state_d        = state_q;
    old_x_d        = old_x_q;
    old_y_d        = old_y_q;
    new_x_d        = new_x_q;
    new_y_d        = new_y_q;
    wt_d           = wt_q;
    src_d          = src_q;
    dst_d          = dst_q;
    h_delta_d      = h_delta_q;
    v_delta_d      = v_delta_q;
    chk_en_d       = chk_en_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    result_valid_d = 1'b0;
    result_move_d  = result_move_q;
    result_code_d  = result_code_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          old_x_d = bus.old_x;
          old_y_d = bus.old_y;
          new_x_d = bus.new_x;
          new_y_d = bus.new_y;
          wt_d    = bus.white_turn;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        src_d     = bus.board_in[old_y_q][old_x_q];
        dst_d     = bus.board_in[new_y_q][new_x_q];
        h_delta_d = h_delta;
        v_delta_d = v_delta;
        state_d   = S_PRECHECK;
      end

      S_PRECHECK: begin
        result_move_d = 1'b0;
        state_d       = S_DONE;
        if (is_empty(src_q)) begin
          result_code_d  = RC_EMPTY_SRC;
          result_valid_d = 1'b1;
        end else if (is_white(src_q) != wt_q) begin
          result_code_d  = RC_WRONG_TURN;
          result_valid_d = 1'b1;
        end else if ((h_delta_q == 3'd0) && (v_delta_q == 3'd0)) begin
          result_code_d  = RC_NULL_MOVE;
          result_valid_d = 1'b1;
        end else if (!is_empty(dst_q) && (is_white(dst_q) == is_white(src_q))) begin
          result_code_d  = RC_OWN_CAPTURE;
          result_valid_d = 1'b1;
        end else begin
          chk_en_d = '0;
          case (piece_kind(src_q))
            3'd0:    chk_en_d[CHK_KING]   = 1'b1;
            3'd1:    chk_en_d[CHK_QUEEN]  = 1'b1;
            3'd2:    chk_en_d[CHK_ROOK]   = 1'b1;
            3'd3:    chk_en_d[CHK_BISHOP] = 1'b1;
            3'd4:    chk_en_d[CHK_KNIGHT] = 1'b1;
            default: chk_en_d[CHK_PAWN]   = 1'b1;
          endcase
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A done arriving on the timeout cycle still counts as a real answer.
        if (sel_done) begin
          result_move_d  = sel_valid;
          result_code_d  = sel_valid ? RC_OK : RC_RULE_FAIL;
          result_valid_d = 1'b1;
          chk_en_d       = '0;
          state_d        = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          result_move_d  = 1'b0;
          result_code_d  = RC_TIMEOUT;
          result_valid_d = 1'b1;
          chk_en_d       = '0;
          state_d        = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      old_x_q        <= '0;
      old_y_q        <= '0;
      new_x_q        <= '0;
      new_y_q        <= '0;
      wt_q           <= 1'b0;
      src_q          <= '0;
      dst_q          <= '0;
      h_delta_q      <= '0;
      v_delta_q      <= '0;
      chk_en_q       <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_move_q  <= 1'b0;
      result_code_q  <= '0;
    end else begin
      state_q        <= state_d;
      old_x_q        <= old_x_d;
      old_y_q        <= old_y_d;
      new_x_q        <= new_x_d;
      new_y_q        <= new_y_d;
      wt_q           <= wt_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      h_delta_q      <= h_delta_d;
      v_delta_q      <= v_delta_d;
      chk_en_q       <= chk_en_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_move_q  <= result_move_d;
      result_code_q  <= result_code_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.chk_en         = chk_en_q;
  assign bus.chk_old_x      = old_x_q;
  assign bus.chk_old_y      = old_y_q;
  assign bus.chk_new_x      = new_x_q;
  assign bus.chk_new_y      = new_y_q;
  assign bus.chk_h_delta    = h_delta_q;
  assign bus.chk_v_delta    = v_delta_q;
  assign bus.chk_piece_type = src_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.result_move    = result_move_q;
  assign bus.result_code    = result_code_q;

endmodule

// File: tb/tb_move_check_sequencer.sv
module tb_move_check_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  move_check_sequencer_if bus();

  move_check_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference board held as plain integers.
  int mb [8][8];

  // Observations collected by the driver (no comparisons there).
  int         o_rv_cyc, o_en_cyc, o_rv_cnt, o_en_cycles;
  logic [5:0] o_en_val, o_en_at_rv;
  logic       o_busy1, o_busy_after, o_mv;
  logic [2:0] o_code, o_hd, o_vd;
  logic [3:0] o_pt;

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) mb[y][x] = 15;
  endtask

  task automatic load_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) bus.board_in[y][x] = 4'(mb[y][x]);
  endtask

  // Reference behaviour from the rules: returns the expected reason code.
  function automatic int model_code(int ox, int oy, int nx, int ny, bit wt,
                                    int delay, bit vld);
    int  src, dst;
    bit  src_w, dst_w;
    src   = mb[oy][ox];
    dst   = mb[ny][nx];
    src_w = (src < 6);
    dst_w = (dst < 6);
    if (src > 11)                         return 1;
    if (src_w != wt)                      return 2;
    if (ox == nx && oy == ny)             return 4;
    if (dst <= 11 && dst_w == src_w)      return 3;
    if (delay < 0)                        return 6;
    return vld ? 0 : 5;
  endfunction

  function automatic int model_rv_cycle(int code, int delay);
    if (code >= 1 && code <= 4) return 3;
    if (code == 6)              return 3 + 16 + 1;
    return 3 + delay + 1;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Issues one request and plays the checker side; cycle 0 is the start cycle.
  task automatic do_move(input int ox, input int oy, input int nx, input int ny,
                         input bit wt, input int delay, input bit vld,
                         input int spur_t, input int mstart_t);
    logic [5:0] done_v, valid_v;
    load_board();
    @(negedge clk);
    bus.old_x = 3'(ox);
    bus.old_y = 3'(oy);
    bus.new_x = 3'(nx);
    bus.new_y = 3'(ny);
    bus.white_turn = wt;
    bus.start = 1'b1;
    o_rv_cyc = -1; o_en_cyc = -1; o_rv_cnt = 0; o_en_cycles = 0;
    o_en_val = '0; o_en_at_rv = '1; o_busy1 = 1'b0; o_busy_after = 1'b1;
    o_mv = 1'b0; o_code = '0; o_hd = '0; o_vd = '0; o_pt = '0;
    for (int t = 1; t <= 32; t++) begin
      @(negedge clk);
      bus.start = (t == mstart_t);
      if (t == 1) o_busy1 = bus.busy;
      if (bus.chk_en != '0) o_en_cycles++;
      if (o_en_cyc < 0 && bus.chk_en != '0) begin
        o_en_cyc = t;
        o_en_val = bus.chk_en;
        o_hd     = bus.chk_h_delta;
        o_vd     = bus.chk_v_delta;
        o_pt     = bus.chk_piece_type;
      end
      if (bus.result_valid) begin
        o_rv_cnt++;
        if (o_rv_cyc < 0) begin
          o_rv_cyc   = t;
          o_mv       = bus.result_move;
          o_code     = bus.result_code;
          o_en_at_rv = bus.chk_en;
        end
      end
      if (o_rv_cyc >= 0 && t == o_rv_cyc + 1) o_busy_after = bus.busy;
      done_v = '0;
      valid_v = '0;
      if (o_en_cyc >= 0 && delay >= 0 && t == o_en_cyc + delay) begin
        done_v  = o_en_val;
        valid_v = vld ? o_en_val : 6'd0;
      end
      if (t == spur_t) begin
        done_v[0]  = 1'b1;
        valid_v[0] = 1'b1;
      end
      bus.chk_done  = done_v;
      bus.chk_valid = valid_v;
    end
    bus.start = 1'b0;
    bus.chk_done = '0;
    bus.chk_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.chk_en !== 6'd0) begin errors++; $display("FAIL reset_chk_en: got %b want 0", bus.chk_en); end
    checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", bus.result_valid); end
    checks++; if ({bus.result_move, bus.result_code} !== 4'd0) begin errors++; $display("FAIL reset_result: got %b/%0d want 0/0", bus.result_move, bus.result_code); end
    checks++; if ({bus.chk_old_x, bus.chk_old_y, bus.chk_new_x, bus.chk_new_y, bus.chk_h_delta, bus.chk_v_delta, bus.chk_piece_type} !== 22'd0) begin
      errors++; $display("FAIL reset_chk_bus: got nonzero latched coords/deltas/piece");
    end
    reset = 1'b0;
  endtask

  task automatic test_pawn();
    clear_board();
    mb[6][4] = 5;
    do_move(4, 6, 4, 4, 1'b1, 2, 1'b1, 0, 0);
    checks++; if (o_en_val !== 6'b100000) begin errors++; $display("FAIL pawn_chk_en: got %b want 100000", o_en_val); end
    checks++; if (o_en_cyc !== 3) begin errors++; $display("FAIL pawn_en_cycle: got %0d want 3", o_en_cyc); end
    checks++; if (o_vd !== 3'd2 || o_hd !== 3'd0) begin errors++; $display("FAIL pawn_deltas: got h%0d v%0d want h0 v2", o_hd, o_vd); end
    checks++; if (o_pt !== 4'd5) begin errors++; $display("FAIL pawn_piece: got %0d want 5", o_pt); end
    checks++; if (o_rv_cyc !== o_en_cyc + 3) begin errors++; $display("FAIL pawn_latency: got %0d want %0d", o_rv_cyc, o_en_cyc + 3); end
    checks++; if (o_mv !== 1'b1 || o_code !== 3'd0) begin errors++; $display("FAIL pawn_result: got %b/%0d want 1/0", o_mv, o_code); end
    checks++; if (o_rv_cnt !== 1) begin errors++; $display("FAIL pawn_rv_count: got %0d want 1", o_rv_cnt); end
    checks++; if (o_busy1 !== 1'b1 || o_busy_after !== 1'b0) begin errors++; $display("FAIL pawn_busy: got %b,%b want 1,0", o_busy1, o_busy_after); end
    checks++; if (o_en_cycles !== 3) begin errors++; $display("FAIL pawn_en_width: got %0d want 3", o_en_cycles); end
  endtask

  task automatic test_empty_src();
    clear_board();
    do_move(3, 3, 3, 5, 1'b1, 1, 1'b1, 0, 0);
    checks++; if (o_rv_cyc !== 3) begin errors++; $display("FAIL empty_latency: got %0d want 3", o_rv_cyc); end
    checks++; if (o_mv !== 1'b0 || o_code !== 3'd1) begin errors++; $display("FAIL empty_result: got %b/%0d want 0/1", o_mv, o_code); end
    checks++; if (o_en_cyc !== -1) begin errors++; $display("FAIL empty_chk_en: got cycle %0d want never", o_en_cyc); end
  endtask

  task automatic test_generic_rules();
    clear_board();
    mb[0][0] = 8;
    do_move(0, 0, 0, 3, 1'b1, 1, 1'b1, 0, 0);
    checks++; if (o_code !== 3'd2 || o_rv_cyc !== 3) begin errors++; $display("FAIL wrong_turn: got code %0d at %0d want 2 at 3", o_code, o_rv_cyc); end
    mb[0][0] = 2;
    mb[4][0] = 4;
    do_move(0, 0, 0, 4, 1'b1, 1, 1'b1, 0, 0);
    checks++; if (o_code !== 3'd3 || o_mv !== 1'b0 || o_en_cyc !== -1) begin errors++; $display("FAIL own_capture: got code %0d mv %b en %0d want 3/0/never", o_code, o_mv, o_en_cyc); end
    do_move(0, 0, 0, 0, 1'b1, 1, 1'b1, 0, 0);
    checks++; if (o_code !== 3'd4 || o_rv_cyc !== 3) begin errors++; $display("FAIL null_move: got code %0d at %0d want 4 at 3", o_code, o_rv_cyc); end
  endtask

  task automatic test_timeout();
    clear_board();
    mb[2][2] = 4;
    do_move(2, 2, 3, 4, 1'b1, -1, 1'b1, 0, 0);
    checks++; if (o_rv_cyc !== 20) begin errors++; $display("FAIL timeout_latency: got %0d want 20", o_rv_cyc); end
    checks++; if (o_code !== 3'd6 || o_mv !== 1'b0) begin errors++; $display("FAIL timeout_result: got %b/%0d want 0/6", o_mv, o_code); end
    checks++; if (o_en_at_rv !== 6'd0 || o_en_cycles !== 17) begin errors++; $display("FAIL timeout_chk_en: got %b after, %0d cycles high want 0, 17", o_en_at_rv, o_en_cycles); end
  endtask

  task automatic test_spurious_and_restart();
    clear_board();
    mb[7][1] = 10;
    do_move(1, 7, 2, 5, 1'b0, 4, 1'b0, 4, 5);
    checks++; if (o_en_val !== 6'b010000) begin errors++; $display("FAIL spur_chk_en: got %b want 010000", o_en_val); end
    checks++; if (o_code !== 3'd5 || o_mv !== 1'b0) begin errors++; $display("FAIL spur_result: got %b/%0d want 0/5", o_mv, o_code); end
    checks++; if (o_rv_cnt !== 1 || o_rv_cyc !== 8) begin errors++; $display("FAIL spur_single: got %0d pulses first at %0d want 1 at 8", o_rv_cnt, o_rv_cyc); end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    bit en_found;
    clear_board();
    mb[6][4] = 5;
    load_board();
    @(negedge clk);
    bus.old_x = 3'd4; bus.old_y = 3'd6; bus.new_x = 3'd4; bus.new_y = 3'd4;
    bus.white_turn = 1'b1;
    bus.start = 1'b1;
    en_found = 1'b0;
    for (int t = 1; t <= 10 && !en_found; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.chk_en != '0) en_found = 1'b1;
    end
    checks++; if (!en_found) begin errors++; $display("FAIL rstmid_reach_wait: got no chk_en within 10 cycles want chk_en"); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.chk_en !== 6'd0 || bus.result_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: got busy %b en %b rv %b want 0 0 0", bus.busy, bus.chk_en, bus.result_valid);
    end
    reset = 1'b0;
    rv_seen = 0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (bus.result_valid) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rstmid_no_result: got %0d pulses want 0", rv_seen); end
    do_move(4, 6, 4, 4, 1'b1, 1, 1'b1, 0, 0);
    checks++; if (o_code !== 3'd0 || o_mv !== 1'b1 || o_rv_cyc !== 5) begin errors++; $display("FAIL rstmid_rerun: got %b/%0d at %0d want 1/0 at 5", o_mv, o_code, o_rv_cyc); end
  endtask

  task automatic test_random();
    int ox, oy, nx, ny, delay, ecode, erv;
    bit wt, vld;
    for (int it = 0; it < 40; it++) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) mb[y][x] = $urandom_range(0, 15);
      ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
      nx = $urandom_range(0, 7); ny = $urandom_range(0, 7);
      wt = 1'($urandom_range(0, 1));
      vld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        mb[oy][ox] = wt ? $urandom_range(0, 5) : $urandom_range(6, 11);
      delay = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 5);
      ecode = model_code(ox, oy, nx, ny, wt, delay, vld);
      erv   = model_rv_cycle(ecode, delay);
      do_move(ox, oy, nx, ny, wt, delay, vld, 0, 0);
      checks++; if (o_code !== 3'(ecode) || o_mv !== (ecode == 0)) begin
        errors++; $display("FAIL rand%0d_result: got %b/%0d want %b/%0d", it, o_mv, o_code, (ecode == 0), ecode);
      end
      checks++; if (o_rv_cyc !== erv || o_rv_cnt !== 1) begin
        errors++; $display("FAIL rand%0d_timing: got %0d pulses first at %0d want 1 at %0d", it, o_rv_cnt, o_rv_cyc, erv);
      end
      if (ecode == 0 || ecode >= 5) begin
        checks++; if (o_en_val !== 6'(1 << (mb[oy][ox] % 6)) || o_en_cyc !== 3) begin
          errors++; $display("FAIL rand%0d_chk_en: got %b at %0d want %b at 3", it, o_en_val, o_en_cyc, 6'(1 << (mb[oy][ox] % 6)));
        end
        checks++; if (o_hd !== 3'(iabs(nx - ox)) || o_vd !== 3'(iabs(ny - oy))) begin
          errors++; $display("FAIL rand%0d_deltas: got h%0d v%0d want h%0d v%0d", it, o_hd, o_vd, iabs(nx - ox), iabs(ny - oy));
        end
      end else begin
        checks++; if (o_en_cyc !== -1) begin
          errors++; $display("FAIL rand%0d_no_chk_en: got cycle %0d want never", it, o_en_cyc);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.old_x = '0; bus.old_y = '0; bus.new_x = '0; bus.new_y = '0;
    bus.white_turn = 1'b0;
    bus.chk_done = '0;
    bus.chk_valid = '0;
    clear_board();
    load_board();
    test_reset();
    test_pawn();
    test_empty_src();
    test_generic_rules();
    test_timeout();
    test_spurious_and_restart();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
